// File: rtl/uart_frame_packer.sv
// Frame packer: snapshots NUM_FIELDS fields and streams sync bytes,
// little-endian payload and an optional sum checksum into a byte UART.
module uart_frame_packer #(
  parameter int         NUM_FIELDS   = 6,
  parameter int         FIELD_W      = 10,
  parameter int         SYNC_BYTES   = 3,
  parameter logic [7:0] SYNC_VALUE   = 8'hFF,
  parameter int         GAP_CYCLES   = 18620,
  parameter bit         USE_CHECKSUM = 1'b1,
  parameter bit         AUTO         = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
  input  logic                          frame_req,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          frame_busy,
  output logic                          frame_done
);

  localparam int BPF      = (FIELD_W + 7) / 8;
  localparam int PAY      = NUM_FIELDS * BPF;
  localparam int TOTAL    = SYNC_BYTES + PAY + (USE_CHECKSUM ? 1 : 0);
  localparam int IW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;

  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

  if (NUM_FIELDS < 1 || NUM_FIELDS > 16) begin : g_bad_nf
    $error("NUM_FIELDS must be 1..16");
  end
  if (FIELD_W < 1 || FIELD_W > 32) begin : g_bad_fw
    $error("FIELD_W must be 1..32");
  end
  if (SYNC_BYTES < 0 || SYNC_BYTES > 7) begin : g_bad_sync
    $error("SYNC_BYTES must be 0..7");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [NUM_FIELDS*FIELD_W-1:0] snap;
  logic [PAY*8-1:0]              payload;
  logic [IW-1:0]                 byte_idx;
  logic [GW-1:0]                 gap_cnt;
  logic [7:0]                    csum;
  logic [7:0]                    cur_byte;
  logic                          cur_pay;
  logic                          pending;
  int                            pidx;

  logic trigger;
  logic start_frame;
  logic load_byte;
  logic gap_step;
  logic next_byte;
  logic finish;

  assign trigger = frame_req | pending | AUTO;

  // Each field zero-extended to a whole number of bytes.
  always_comb begin
    payload = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      payload[k*BPF*8 +: FIELD_W] = snap[k*FIELD_W +: FIELD_W];
    end
  end

  // Past the payload only the checksum slot remains.
  always_comb begin
    cur_byte = csum;
    cur_pay  = 1'b0;
    pidx     = int'(byte_idx) - SYNC_BYTES;
    if (pidx < 0) begin
      cur_byte = SYNC_VALUE;
    end else if (pidx < PAY) begin
      cur_byte = payload[pidx*8 +: 8];
      cur_pay  = 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    load_byte   = 1'b0;
    tx_start    = 1'b0;
    gap_step    = 1'b0;
    next_byte   = 1'b0;
    finish      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (trigger) begin
          start_frame = 1'b1;
          state_n     = S_LOAD;
        end
      end
      S_LOAD: begin
        load_byte = 1'b1;
        state_n   = S_ISSUE;
      end
      S_ISSUE: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt >= GAP_END) begin
          state_n = S_WAIT;
        end else begin
          gap_step = 1'b1;
        end
      end
      S_WAIT: begin
        if (tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            finish  = 1'b1;
            state_n = S_IDLE;
          end else begin
            next_byte = 1'b1;
            state_n   = S_LOAD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      snap       <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      csum       <= '0;
      tx_data    <= '0;
      pending    <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= finish;
      if (start_frame) begin
        snap       <= fields_in;
        byte_idx   <= '0;
        csum       <= '0;
        frame_busy <= 1'b1;
      end else if (finish) begin
        frame_busy <= 1'b0;
      end
      if (start_frame) begin
        pending <= 1'b0;
      end else if (frame_req && frame_busy && !AUTO) begin
        pending <= 1'b1;
      end
      if (load_byte) begin
        tx_data <= cur_byte;
        if (cur_pay) begin
          csum <= csum + cur_byte;
        end
      end
      if (tx_start) begin
        gap_cnt <= '0;
      end else if (gap_step) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
      if (next_byte) begin
        byte_idx <= byte_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: request-driven instance plus an
// AUTO instance, checked against a byte-list frame model.
`timescale 1ns/1ps
module tb_uart_frame_packer;

  localparam int NF    = 2;
  localparam int FW    = 10;
  localparam int SB    = 2;
  localparam int GAP   = 4;
  localparam int BPF   = 2;
  localparam int TOT_A = 7;
  localparam int TOT_B = 6;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, frame_req, tx_ready;
  logic [NF*FW-1:0] fields;
  logic [7:0]       tx_data;
  logic             tx_start, frame_busy, frame_done;

  logic             rst_b, frame_req_b, tx_ready_b;
  logic [NF*FW-1:0] fields_b;
  logic [7:0]       tx_data_b;
  logic             tx_start_b, frame_busy_b, frame_done_b;

  uart_frame_packer #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .SYNC_BYTES(SB),
    .SYNC_VALUE(8'hFF), .GAP_CYCLES(GAP),
    .USE_CHECKSUM(1'b1), .AUTO(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .fields_in(fields),
    .frame_req(frame_req), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_start(tx_start),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  uart_frame_packer #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .SYNC_BYTES(SB),
    .SYNC_VALUE(8'hFF), .GAP_CYCLES(GAP),
    .USE_CHECKSUM(1'b0), .AUTO(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .fields_in(fields_b),
    .frame_req(frame_req_b), .tx_ready(tx_ready_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b),
    .frame_busy(frame_busy_b), .frame_done(frame_done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as a plain byte list: sync, fields LSB first, sum mod 256.
  function automatic bq_t model(input logic [NF*FW-1:0] f, input bit cs);
    bq_t         q;
    int          sum;
    logic [31:0] v;
    q   = {};
    sum = 0;
    for (int i = 0; i < SB; i++) q.push_back(8'hFF);
    for (int k = 0; k < NF; k++) begin
      v = 32'(f[k*FW +: FW]);
      for (int j = 0; j < BPF; j++) begin
        q.push_back(v[j*8 +: 8]);
        sum += int'(v[j*8 +: 8]);
      end
    end
    if (cs) q.push_back(8'(sum % 256));
    return q;
  endfunction

  logic [7:0] t1_lit [7] = '{8'hFF, 8'hFF, 8'hA5, 8'h02, 8'hF3, 8'h00, 8'h9A};
  // 0xFF+0x03+0xFF+0x03 = 0x204
  logic [7:0] t3_lit [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h03, 8'hFF, 8'h03, 8'h04};

  bq_t exp_q, rx_q, frame_b, pin;
  int  cyc = 0, last_a = -1, nbytes_a = 0, starts_a = 0, dones_a = 0;
  int  cyc_b = 0, last_b = -1, nb_b = 0, dones_b = 0, done_cyc_b = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", frame_busy, 0);
      check("rst_done", frame_done, 0);
      nbytes_a = 0;
      last_a   = -1;
    end else begin
      if (tx_start) begin
        check("start_needs_ready", tx_ready, 1);
        check("busy_on_start", frame_busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          check("byte", tx_data, exp_q.pop_front());
        end
        if (last_a >= 0) check("spacing", (cyc - last_a) >= GAP + 2, 1);
        last_a = cyc;
        nbytes_a++;
        starts_a++;
        rx_q.push_back(tx_data);
      end
      if (frame_done) begin
        check("frame_len", nbytes_a, TOT_A);
        check("busy_at_done", frame_busy, 0);
        nbytes_a = 0;
        dones_a++;
      end
    end
  end

  always @(negedge clk) begin
    cyc_b++;
    if (!rst_b) begin
      if (tx_start_b) begin
        if (nb_b < TOT_B) check("b_byte", tx_data_b, frame_b[nb_b]);
        else check("b_overrun", nb_b, TOT_B - 1);
        if (last_b >= 0) check("b_spacing", (cyc_b - last_b) >= GAP + 2, 1);
        if (nb_b == 0 && done_cyc_b >= 0) check("b_restart", cyc_b - done_cyc_b, 2);
        last_b = cyc_b;
        nb_b++;
      end
      if (frame_done_b) begin
        check("b_len", nb_b, TOT_B);
        nb_b       = 0;
        done_cyc_b = cyc_b;
        dones_b++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
  endtask

  task automatic wait_starts(int n, string tag);
    int target;
    int k;
    target = starts_a + n;
    k = 0;
    while (starts_a < target && k < 2000) begin
      tick(1);
      k++;
    end
    check({tag, "_starts_wait"}, starts_a >= target, 1);
  endtask

  task automatic wait_dones(int n, string tag);
    int target;
    int k;
    target = dones_a + n;
    k = 0;
    while (dones_a < target && k < 2000) begin
      tick(1);
      k++;
    end
    check({tag, "_done_wait"}, dones_a >= target, 1);
  endtask

  task automatic push_frame(input logic [NF*FW-1:0] f);
    bq_t fr;
    fr = model(f, 1'b1);
    foreach (fr[i]) exp_q.push_back(fr[i]);
  endtask

  initial begin
    int c0, d0;
    rst = 1'b1;
    rst_b = 1'b1;
    frame_req = 1'b0;
    frame_req_b = 1'b0;
    tx_ready = 1'b1;
    tx_ready_b = 1'b1;
    fields = {10'h0F3, 10'h2A5};
    fields_b = {10'h155, 10'h0AA};
    frame_b = model(fields_b, 1'b0);
    exp_q = {};
    rx_q = {};
    tick(3);
    rst = 1'b0;
    rst_b = 1'b0;
    tick(2);
    check("idle_busy", frame_busy, 0);
    check("idle_data", tx_data, 0);
    check("idle_start", tx_start, 0);

    pin = model({10'h0F3, 10'h2A5}, 1'b1);
    check("pin_t1_len", pin.size(), 7);
    check("pin_t1_csum", pin[6], 8'h9A);
    pin = model({10'h3FF, 10'h3FF}, 1'b1);
    check("pin_t3_csum", pin[6], 8'h04);
    pin = model({10'h155, 10'h0AA}, 1'b0);
    check("pin_b_len", pin.size(), TOT_B);
    check("pin_b_b4", pin[4], 8'h55);

    // T1 basic frame
    rx_q = {};
    push_frame(fields);
    pulse_req();
    wait_dones(1, "t1");
    check("t1_rx_len", rx_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < rx_q.size()) check($sformatf("t1_b%0d", i), rx_q[i], t1_lit[i]);
    tick(3);
    check("t1_busy_after", frame_busy, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // T2 tx_ready stall
    rx_q = {};
    push_frame(fields);
    pulse_req();
    wait_starts(3, "t2");
    tx_ready = 1'b0;
    c0 = starts_a;
    tick(20);
    check("t2_no_start_stalled", starts_a, c0);
    tx_ready = 1'b1;
    tick(3);
    check("t2_byte4_resume", starts_a, c0 + 1);
    wait_dones(1, "t2");
    check("t2_rx_len", rx_q.size(), 7);
    check("t2_q_empty", exp_q.size(), 0);

    // T3 snapshot + pending frame
    rx_q = {};
    push_frame(fields);
    push_frame({10'h3FF, 10'h3FF});
    pulse_req();
    wait_starts(2, "t3");
    fields = '1;
    pulse_req();
    wait_dones(2, "t3");
    check("t3_rx_len", rx_q.size(), 14);
    for (int i = 0; i < 7; i++)
      if (i + 7 < rx_q.size()) check($sformatf("t3_b%0d", i), rx_q[i+7], t3_lit[i]);

    // T4 merged requests
    tick(2);
    fields = {10'h3C0, 10'h001};
    push_frame(fields);
    push_frame(fields);
    pulse_req();
    wait_starts(1, "t4");
    pulse_req();
    tick(2);
    pulse_req();
    tick(5);
    pulse_req();
    wait_dones(2, "t4");
    d0 = dones_a;
    tick(60);
    check("t4_no_third", dones_a, d0);
    check("t4_busy_low", frame_busy, 0);
    check("t4_q_empty", exp_q.size(), 0);

    // T6 reset mid-frame
    fields = {10'h100, 10'h0FF};
    push_frame(fields);
    pulse_req();
    wait_starts(2, "t6");
    rst = 1'b1;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    check("t6_idle_after_rst", frame_busy, 0);
    rx_q = {};
    push_frame(fields);
    pulse_req();
    wait_dones(1, "t6");
    check("t6_rx_len", rx_q.size(), 7);
    if (rx_q.size() == 7) begin
      check("t6_sync_first", rx_q[0], 8'hFF);
      check("t6_fresh_csum", rx_q[6], 8'h00);
      check("t6_b5", rx_q[5], 8'h01);
    end
    tick(5);

    check("b_frames", dones_b >= 3, 1);
    check("b_busy_auto", frame_busy_b | frame_done_b | tx_start_b | (nb_b > 0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
